// File: rtl/axi_rr_arbiter.sv
// N-to-1 request arbiter: round-robin or fixed priority, burst locking, stable grant.
// Define AXI_ARB_LOCK_TIMEOUT_EN to release a lock whose owner stays idle for TIMEOUT_CYCLES.
module axi_rr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int SEL_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   in_req_i,
    input  logic [NUM_REQ-1:0]   in_last_i,
    output logic [NUM_REQ-1:0]   in_ack_o,
    input  logic                 prio_mode_i,
    output logic                 out_req_o,
    output logic                 out_last_o,
    input  logic                 out_ack_i,
    output logic [SEL_WIDTH-1:0] out_sel_o,
    output logic                 timeout_o
);

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SEL_WIDTH-1:0] r_rr_ptr;
    logic [SEL_WIDTH-1:0] w_rr_ptr_nxt;
    logic [SEL_WIDTH-1:0] r_lock_sel;
    logic [SEL_WIDTH-1:0] w_lock_sel_nxt;
    logic [SEL_WIDTH-1:0] w_winner;
    logic [SEL_WIDTH-1:0] w_sel;
    logic                 w_found;
    logic                 w_any_req;
    logic                 w_out_req;
    logic                 w_last_hs;
    int                   w_rr_idx;

    if (NUM_REQ < 1) begin : g_bad_num_req
        $error("NUM_REQ must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    // Pointer successor, wrapping NUM_REQ-1 back to 0 (also keeps it at 0 when NUM_REQ = 1).
    function automatic logic [SEL_WIDTH-1:0] f_wrap_inc(input logic [SEL_WIDTH-1:0] v);
        if (int'(v) >= NUM_REQ - 1)
            return '0;
        else
            return v + 1'b1;
    endfunction

    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_rr_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (prio_mode_i) begin
                w_rr_idx = i;
            end else begin
                w_rr_idx = int'(r_rr_ptr) + i;
                if (w_rr_idx >= NUM_REQ)
                    w_rr_idx = w_rr_idx - NUM_REQ;
            end
            if (!w_found && in_req_i[w_rr_idx]) begin
                w_found  = 1'b1;
                w_winner = SEL_WIDTH'(w_rr_idx);
            end
        end
    end

    assign w_any_req = |in_req_i;

    always_comb begin
        if (r_state == ST_LOCKED) begin
            w_sel     = r_lock_sel;
            w_out_req = in_req_i[r_lock_sel];
        end else begin
            w_sel     = w_winner;
            w_out_req = w_any_req;
        end
        w_last_hs = w_out_req & out_ack_i & in_last_i[w_sel];
    end

`ifdef AXI_ARB_LOCK_TIMEOUT_EN
    logic [7:0] r_idle_cnt;
    logic [7:0] w_idle_cnt_nxt;
    logic       r_timeout;
    logic       w_timeout_nxt;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_lock_sel_nxt = r_lock_sel;
`ifdef AXI_ARB_LOCK_TIMEOUT_EN
        w_idle_cnt_nxt = '0;
        w_timeout_nxt  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_last_hs) begin
                    w_rr_ptr_nxt = f_wrap_inc(w_winner);
                end else if (w_any_req) begin
                    // Covers both an un-acked beat and a non-last beat: freeze the choice.
                    w_state_nxt    = ST_LOCKED;
                    w_lock_sel_nxt = w_winner;
                end
            end
            ST_LOCKED: begin
                if (w_last_hs) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = f_wrap_inc(r_lock_sel);
                end
`ifdef AXI_ARB_LOCK_TIMEOUT_EN
                else if (!in_req_i[r_lock_sel]) begin
                    if (r_idle_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        w_state_nxt   = ST_IDLE;
                        w_rr_ptr_nxt  = f_wrap_inc(r_lock_sel);
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_idle_cnt_nxt = r_idle_cnt + 8'd1;
                    end
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ack_o        = '0;
        in_ack_o[w_sel] = out_ack_i & w_out_req;
        out_req_o       = w_out_req;
        out_last_o      = in_last_i[w_sel] & w_out_req;
        out_sel_o       = w_sel;
`ifdef AXI_ARB_LOCK_TIMEOUT_EN
        timeout_o       = r_timeout;
`else
        timeout_o       = 1'b0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_lock_sel <= '0;
`ifdef AXI_ARB_LOCK_TIMEOUT_EN
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_lock_sel <= w_lock_sel_nxt;
`ifdef AXI_ARB_LOCK_TIMEOUT_EN
            r_idle_cnt <= w_idle_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter: every-cycle model comparison plus literal expectations.
module tb_axi_rr_arbiter;

    localparam int N = 4;
    localparam int TMO = 4;
`ifdef AXI_ARB_LOCK_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_i;
    logic [N-1:0] in_req_i;
    logic [N-1:0] in_last_i;
    logic [N-1:0] in_ack_o;
    logic         prio_mode_i;
    logic         out_req_o;
    logic         out_last_o;
    logic         out_ack_i;
    logic [1:0]   out_sel_o;
    logic         timeout_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    axi_rr_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .in_req_i   (in_req_i),
        .in_last_i  (in_last_i),
        .in_ack_o   (in_ack_o),
        .prio_mode_i(prio_mode_i),
        .out_req_o  (out_req_o),
        .out_last_o (out_last_o),
        .out_ack_i  (out_ack_i),
        .out_sel_o  (out_sel_o),
        .timeout_o  (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: owner of the current burst (-1 when free), pointer, idle count.
    int m_lock;
    int m_ptr;
    int m_idle;
    bit m_tmo;

    function automatic int f_winner(input logic [N-1:0] req, input logic prio, input int ptr);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = prio ? k : (ptr + k) % N;
            if (req[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic int f_exp_sel();
        if (m_lock >= 0) return m_lock;
        return f_winner(in_req_i, prio_mode_i, m_ptr);
    endfunction

    function automatic bit f_exp_req();
        if (m_lock >= 0) return in_req_i[m_lock];
        return |in_req_i;
    endfunction

    always @(posedge clk) begin
        int  sel;
        bit  oreq;
        bit  last_hs;
        if (rst_i) begin
            m_lock = -1;
            m_ptr  = 0;
            m_idle = 0;
            m_tmo  = 1'b0;
        end else begin
            sel     = f_exp_sel();
            oreq    = f_exp_req();
            last_hs = oreq && out_ack_i && in_last_i[sel];
            m_tmo   = 1'b0;
            if (m_lock < 0) begin
                if (last_hs) m_ptr = (sel + 1) % N;
                else if (oreq) m_lock = sel;
                m_idle = 0;
            end else if (last_hs) begin
                m_ptr  = (m_lock + 1) % N;
                m_lock = -1;
                m_idle = 0;
            end else if (TMO_EN && !in_req_i[m_lock]) begin
                if (m_idle == TMO - 1) begin
                    m_ptr  = (m_lock + 1) % N;
                    m_lock = -1;
                    m_idle = 0;
                    m_tmo  = 1'b1;
                end else begin
                    m_idle = m_idle + 1;
                end
            end else begin
                m_idle = 0;
            end
        end
    end

    always @(negedge clk) begin
        int sel;
        bit oreq;
        if (chk_en) begin
            sel  = f_exp_sel();
            oreq = f_exp_req();
            chk("model_out_req", 32'(out_req_o), 32'(oreq));
            chk("model_out_sel", 32'(out_sel_o), 32'(sel));
            chk("model_in_ack", 32'(in_ack_o), (oreq && out_ack_i) ? (32'd1 << sel) : 32'd0);
            chk("model_out_last", 32'(out_last_o), 32'(oreq && in_last_i[sel]));
            chk("model_timeout", 32'(timeout_o), 32'(m_tmo));
        end
    end

    // Advance one cycle, apply inputs, leave time for outputs to settle before the checks.
    task automatic step(input logic [N-1:0] req, input logic [N-1:0] last,
                        input logic ack, input logic prio);
        @(posedge clk);
        #1;
        in_req_i    = req;
        in_last_i   = last;
        out_ack_i   = ack;
        prio_mode_i = prio;
        #3;
    endtask

    initial begin
        rst_i       = 1'b1;
        in_req_i    = '0;
        in_last_i   = '0;
        out_ack_i   = 1'b0;
        prio_mode_i = 1'b0;

        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk_en = 1'b1;
        chk("rst_out_req", 32'(out_req_o), 0);
        chk("rst_out_last", 32'(out_last_o), 0);
        chk("rst_in_ack", 32'(in_ack_o), 0);
        chk("rst_out_sel", 32'(out_sel_o), 0);
        chk("rst_timeout", 32'(timeout_o), 0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        rst_i = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 4'b1111, 1'b1, 1'b0);
            chk("rr_sel", 32'(out_sel_o), i % 4);
            chk("rr_ack", 32'(in_ack_o), 32'd1 << (i % 4));
        end

        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 4'b1111, 1'b1, 1'b1);
            chk("prio_sel", 32'(out_sel_o), 0);
            chk("prio_ack", 32'(in_ack_o), 32'b0001);
        end

        step(4'b0101, 4'b0001, 1'b1, 1'b0);
        chk("burst_sel1", 32'(out_sel_o), 2);
        chk("burst_ack1", 32'(in_ack_o), 32'b0100);
        step(4'b0101, 4'b0001, 1'b1, 1'b0);
        chk("burst_sel2", 32'(out_sel_o), 2);
        chk("burst_ack2", 32'(in_ack_o), 32'b0100);
        step(4'b0101, 4'b0101, 1'b1, 1'b0);
        chk("burst_sel3", 32'(out_sel_o), 2);
        chk("burst_last3", 32'(out_last_o), 1);
        step(4'b0001, 4'b0001, 1'b1, 1'b0);
        chk("burst_after_sel", 32'(out_sel_o), 0);
        chk("burst_after_ack", 32'(in_ack_o), 32'b0001);

        for (int i = 0; i < 5; i++) begin
            step(4'b0100, 4'b0000, 1'b0, 1'b0);
            chk("stall_sel", 32'(out_sel_o), 2);
            chk("stall_ack", 32'(in_ack_o), 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(4'b0110, 4'b0000, 1'b0, 1'b1);
            chk("stall_late_sel", 32'(out_sel_o), 2);
        end
        step(4'b0110, 4'b0100, 1'b1, 1'b0);
        chk("stall_end_ack", 32'(in_ack_o), 32'b0100);
        step(4'b1010, 4'b1010, 1'b1, 1'b0);
        chk("stall_next3", 32'(out_sel_o), 3);
        step(4'b0100, 4'b0000, 1'b0, 1'b0);
        step(4'b0100, 4'b0100, 1'b1, 1'b0);
        step(4'b0010, 4'b0010, 1'b1, 1'b0);
        chk("stall_next1", 32'(out_sel_o), 1);

        step(4'b0010, 4'b0000, 1'b0, 1'b0);
        chk("lock1_sel", 32'(out_sel_o), 1);
        for (int i = 1; i <= 4; i++) begin
            step(4'b0000, 4'b0000, 1'b1, 1'b0);
            chk("drop_sel", 32'(out_sel_o), 1);
            chk("drop_req", 32'(out_req_o), 0);
            chk("drop_timeout", 32'(timeout_o), 0);
        end
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        chk("tmo_pulse", 32'(timeout_o), 32'(TMO_EN));
        chk("tmo_sel", 32'(out_sel_o), TMO_EN ? 0 : 1);
        step(4'b0010, 4'b0010, 1'b1, 1'b0);
        chk("tmo_pulse_end", 32'(timeout_o), 0);
        chk("tmo_resume_sel", 32'(out_sel_o), 1);
        step(4'b1011, 4'b1111, 1'b1, 1'b0);
        chk("tmo_ptr2_sel", 32'(out_sel_o), 3);

        step(4'b1000, 4'b0000, 1'b0, 1'b0);
        step(4'b1000, 4'b0000, 1'b1, 1'b0);
        chk("mid_lock_sel", 32'(out_sel_o), 3);
        rst_i = 1'b1;
        step(4'b1001, 4'b0000, 1'b0, 1'b0);
        chk("mid_rst_sel", 32'(out_sel_o), 0);
        rst_i = 1'b0;
        step(4'b1001, 4'b1001, 1'b1, 1'b0);
        chk("post_rst_sel", 32'(out_sel_o), 0);
        step(4'b1001, 4'b1001, 1'b1, 1'b0);
        chk("post_rst_rr", 32'(out_sel_o), 3);

        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
